// File: rtl/spi_adc_seq_pkg.sv
// Shared definitions for the spi_adc_seq acquisition sequencer: FSM state
// encoding, command byte constants and the averaging shift amount.
package spi_adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SEND0    = 3'd2,
        ST_WAIT0    = 3'd3,
        ST_SEND1    = 3'd4,
        ST_WAIT1    = 3'd5,
        ST_CS_HOLD  = 3'd6
    } state_t;

    localparam logic [1:0] CMD_PREFIX = 2'b11;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;
    localparam int         AVG_SHIFT  = 2;

    // First command byte of a frame: prefix, 3-bit channel, three zero bits.
    function automatic logic [7:0] cmdByte(input logic [2:0] ch);
        return {CMD_PREFIX, ch, 3'b000};
    endfunction

endpackage

// File: rtl/spi_adc_seq_tick.sv
// Sample-period timebase: free-running counter held at zero while disabled,
// producing a one-cycle tick on the wrap cycle.
module spi_adc_seq_tick #(
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Enable,
    output logic o_Tick
);

    localparam int                CNT_W = $clog2(SAMPLE_PERIOD);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SAMPLE_PERIOD - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear while disabled, wrap at the end of the period.
    always_comb begin
        count_d = count_q;
        if (!i_Enable) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Period counter register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Tick = i_Enable && (count_q == LAST);

endmodule

// File: rtl/spi_adc_seq.sv
// Periodic ADC acquisition sequencer driving a byte-level SPI master.
// Owns chip select, issues a two-byte frame per conversion and rotates
// through NUM_CH channels. Define SPI_ADC_SEQ_AVG_EN to average four
// consecutive conversions per channel before reporting a result.
module spi_adc_seq
    import spi_adc_seq_pkg::*;
#(
    parameter  int NUM_CH        = 4,
    parameter  int SAMPLE_PERIOD = 1000,
    parameter  int CS_SETUP_CLKS = 2,
    parameter  int CS_HOLD_CLKS  = 2,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            i_Clk,
    input  logic            i_Rst_L,
    input  logic            i_Enable,
    input  logic            i_Trigger,
    output logic            o_Busy,
    output logic [7:0]      o_TX_Byte,
    output logic            o_TX_DV,
    input  logic            i_TX_Ready,
    input  logic            i_RX_DV,
    input  logic [7:0]      i_RX_Byte,
    output logic            o_SPI_CS_n,
    output logic [15:0]     o_Sample,
    output logic [CH_W-1:0] o_Sample_Ch,
    output logic            o_Sample_DV,
    output logic            o_Overrun
);

    localparam logic [15:0]     SETUP_LAST = 16'(CS_SETUP_CLKS - 1);
    localparam logic [15:0]     HOLD_LAST  = 16'(CS_HOLD_CLKS - 1);
    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       rx0_q, rx0_d;
    logic [7:0]       rx1_q, rx1_d;
    logic             cs_n_q, cs_n_d;
    logic             tx_dv_q, tx_dv_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [15:0]      sample_q, sample_d;
    logic [CH_W-1:0]  sample_ch_q, sample_ch_d;
    logic             sample_dv_q, sample_dv_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic [CH_W-1:0]  ch_next;

`ifdef SPI_ADC_SEQ_AVG_EN
    logic [17:0]      acc_q, acc_d;
    logic [1:0]       rep_q, rep_d;
    logic [17:0]      sum;
`endif

    spi_adc_seq_tick #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_tick (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Enable (i_Enable),
        .o_Tick   (tick)
    );

    assign ch_next = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;

    // Frame sequencing: next state, CS/TX drive, byte capture and result update.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        rx0_d       = rx0_q;
        rx1_d       = rx1_q;
        cs_n_d      = cs_n_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        sample_d    = sample_q;
        sample_ch_d = sample_ch_q;
        sample_dv_d = 1'b0;
        overrun_d   = tick && (state_q != ST_IDLE);
`ifdef SPI_ADC_SEQ_AVG_EN
        acc_d       = acc_q;
        rep_d       = rep_q;
        sum         = acc_q + 18'({rx0_q, rx1_q});
`endif
        case (state_q)
            ST_IDLE: begin
                if (tick || i_Trigger) begin
                    state_d = ST_CS_SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_CS_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_SEND0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND0: begin
                if (i_TX_Ready) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = cmdByte(3'(ch_q));
                    state_d   = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (i_RX_DV) begin
                    rx0_d   = i_RX_Byte;
                    state_d = ST_SEND1;
                end
            end
            ST_SEND1: begin
                if (i_TX_Ready) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = DUMMY_BYTE;
                    state_d   = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (i_RX_DV) begin
                    rx1_d   = i_RX_Byte;
                    state_d = ST_CS_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_CS_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cs_n_d  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef SPI_ADC_SEQ_AVG_EN
                    if (rep_q == 2'd3) begin
                        sample_d    = sum[17:AVG_SHIFT];
                        sample_ch_d = ch_q;
                        sample_dv_d = 1'b1;
                        ch_d        = ch_next;
                        acc_d       = '0;
                        rep_d       = '0;
                    end else begin
                        acc_d = sum;
                        rep_d = rep_q + 1'b1;
                    end
`else
                    sample_d    = {rx0_q, rx1_q};
                    sample_ch_d = ch_q;
                    sample_dv_d = 1'b1;
                    ch_d        = ch_next;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset aborts any frame and releases CS at once.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            rx0_q       <= '0;
            rx1_q       <= '0;
            cs_n_q      <= 1'b1;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
            sample_q    <= '0;
            sample_ch_q <= '0;
            sample_dv_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SPI_ADC_SEQ_AVG_EN
            acc_q       <= '0;
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            rx0_q       <= rx0_d;
            rx1_q       <= rx1_d;
            cs_n_q      <= cs_n_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            sample_q    <= sample_d;
            sample_ch_q <= sample_ch_d;
            sample_dv_q <= sample_dv_d;
            overrun_q   <= overrun_d;
`ifdef SPI_ADC_SEQ_AVG_EN
            acc_q       <= acc_d;
            rep_q       <= rep_d;
`endif
        end
    end

    assign o_Busy      = (state_q != ST_IDLE);
    assign o_TX_Byte   = tx_byte_q;
    assign o_TX_DV     = tx_dv_q;
    assign o_SPI_CS_n  = cs_n_q;
    assign o_Sample    = sample_q;
    assign o_Sample_Ch = sample_ch_q;
    assign o_Sample_DV = sample_dv_q;
    assign o_Overrun   = overrun_q;

endmodule

// File: doc/spi_adc_seq.md
Name: spi_adc_seq

Overview:
Periodic ADC acquisition sequencer that drives the byte-level spi_master (byte handshake via TX_DV/TX_Ready/RX_DV).
- Owns chip-select and paces CS setup/hold.
- Issues a 2-byte command/readback frame per conversion and rotates through NUM_CH channels.
- Presents each 16-bit result with its channel tag to the PID loop.

Parameters:
- NUM_CH, 4, channels scanned (1..8); CH_W = max(1,$clog2(NUM_CH)).
- SAMPLE_PERIOD, 1000, i_Clk cycles between automatic conversion starts (>=64).
- CS_SETUP_CLKS, 2, cycles CS_n low before first TX_DV (>=1).
- CS_HOLD_CLKS, 2, cycles after last RX_DV before CS_n high (>=1).

Ports:
- i_Clk  in  1  clock
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_Enable  in  1  enable periodic conversions
- i_Trigger  in  1  single-cycle start request, honoured only in IDLE
- o_Busy  out  1  high whenever state != IDLE
- o_TX_Byte  out  8  byte to spi_master
- o_TX_DV  out  1  one-cycle pulse to spi_master
- i_TX_Ready  in  1  spi_master ready
- i_RX_DV  in  1  spi_master byte-received pulse
- i_RX_Byte  in  8  spi_master received byte
- o_SPI_CS_n  out  1  ADC chip select, active-low
- o_Sample  out  16  result {rx0, rx1}
- o_Sample_Ch  out  CH_W  channel of o_Sample
- o_Sample_DV  out  1  one-cycle result-valid pulse
- o_Overrun  out  1  one-cycle pulse: period tick dropped while busy

Behaviour:
- Reset values: o_SPI_CS_n=1; o_TX_DV, o_Sample_DV, o_Overrun, o_Busy = 0; o_TX_Byte, o_Sample = 0; o_Sample_Ch, channel pointer, period counter = 0; state = IDLE.
- Reset asserted mid-frame aborts immediately: CS_n high asynchronously, no result emitted.
- Period counter:
  - Held at 0 while i_Enable=0.
  - Otherwise counts 0..SAMPLE_PERIOD-1 and wraps; tick = wrap cycle.
- Start condition is (tick | i_Trigger) while in IDLE.
  - Tick outside IDLE: o_Overrun pulses and the tick is dropped.
  - i_Trigger outside IDLE: silently ignored.
- Command bytes: byte0 = {2'b11, ch[2:0] zero-extended, 3'b000}; byte1 = 8'h00.
- States:
  - IDLE → CS_SETUP on start. CS_n is driven low registered, so the first low cycle is start+1.
  - CS_SETUP: stay CS_SETUP_CLKS cycles → SEND0.
  - SEND0: when i_TX_Ready=1, pulse o_TX_DV for 1 cycle with o_TX_Byte=byte0 → WAIT0. Never re-pulse before the matching i_RX_DV.
  - WAIT0: on i_RX_DV, capture rx0 → SEND1.
  - SEND1: same as SEND0 using byte1 → WAIT1.
  - WAIT1: on i_RX_DV, capture rx1 → CS_HOLD.
  - CS_HOLD: stay CS_HOLD_CLKS cycles, then in one cycle:
    - CS_n=1;
    - o_Sample={rx0,rx1}, o_Sample_Ch=ch, o_Sample_DV=1;
    - ch <= (ch==NUM_CH-1) ? 0 : ch+1;
    - → IDLE.
- i_TX_Ready low in SEND*: wait indefinitely.
- i_RX_DV outside WAIT*: ignored.
- i_Enable deasserted mid-frame: the frame completes normally, then no further ticks. Channel pointer is retained.
- o_Sample/o_Sample_Ch hold their values between DV pulses.
- Back-to-back: a tick coinciding with the IDLE-return cycle counts as busy, so o_Overrun pulses.

Optional Feature:
SPI_ADC_SEQ_AVG_EN
- Defined:
  - 18-bit accumulator; each channel is converted 4 consecutive times before the channel advances.
  - o_Sample_DV pulses only on the 4th conversion, with o_Sample = sum[17:2] (truncating).
  - Accumulator clears on the DV cycle and on reset.
- Undefined: one conversion per channel, raw result, no accumulator logic.

Decomposition:
- Shared package spi_adc_seq_pkg:
  - state encoding (7 states, 3 bits);
  - CMD_PREFIX=2'b11 and DUMMY_BYTE=8'h00;
  - AVG_SHIFT=2.
- One natural sub-module: spi_adc_seq_tick (period counter + enable gating, outputs tick). The FSM stays in the top.

Test Plan:
- Reset, i_Trigger with spi_master model returning 8'hA5 then 8'h3C → CS_n low start+1; TX bytes 8'hC0 then 8'h00; o_Sample=16'hA53C, o_Sample_Ch=0, single DV pulse; CS_n high same cycle.
- i_Enable=1, SAMPLE_PERIOD=1000, NUM_CH=4 → starts every 1000 cycles; channels 0,1,2,3,0; byte0 = C0, C8, D0, D8, C0.
- Model stalls i_RX_DV 1200 cycles → exactly one o_Overrun pulse at the next tick, no extra frame, ch sequence unbroken.
- Assert i_Rst_L=0 during WAIT1 → CS_n=1, o_Busy=0 immediately; no o_Sample_DV; next frame uses ch 0.
- i_Trigger while busy, and spurious i_RX_DV in IDLE → both ignored; exactly one TX_DV per byte, checked by assertion.
- With SPI_ADC_SEQ_AVG_EN, samples 100,101,102,103 on ch0 → one DV, o_Sample=101, o_Sample_Ch=0; 5th conversion is ch1.
